// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection for branch/jump/jr/eret,
// exception entry with epc/cause capture, and a RUN/HALT state machine.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | normal fetch; next pc chosen by the redirect priority chain
// ST_HALT | pc/epc/cause frozen; only exception or resume leave it
module pc_sequencer #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    input  logic             exception,
    input  logic             eret,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       cause,
    output logic             halted,
    output logic             trap
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_EXT  = 2'd1;
    localparam logic [1:0] CAUSE_MIS  = 2'd2;

    logic [0:0]       state_q, state_n;
    logic [WIDTH-1:0] pc_q, pc_n;
    logic [WIDTH-1:0] epc_q, epc_n;
    logic [1:0]       cause_q, cause_n;
    logic             trap_q, trap_n;

    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic             jr_misaligned;

    assign pc_plus4      = pc_q + WIDTH'(4);
    assign branch_target = pc_plus4 + {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign jump_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
    assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        epc_n   = epc_q;
        cause_n = cause_q;
        trap_n  = 1'b0;
        if (state_q == ST_HALT) begin
            if (exception) begin
                pc_n    = EXC_VECTOR;
                epc_n   = pc_q;
                cause_n = CAUSE_EXT;
                trap_n  = 1'b1;
                state_n = ST_RUN;
            end else if (resume) begin
                state_n = ST_RUN;
            end
        end else begin
            // misaligned jr traps even under stall: it ranks above stall
            if (exception || jr_misaligned) begin
                pc_n    = EXC_VECTOR;
                epc_n   = pc_q;
                cause_n = exception ? CAUSE_EXT : CAUSE_MIS;
                trap_n  = 1'b1;
            end else if (halt) begin
                state_n = ST_HALT;
            end else if (eret) begin
                pc_n    = epc_q;
                cause_n = CAUSE_NONE;
            end else if (stall) begin
                pc_n = pc_q;
            end else if (jr) begin
                pc_n = jr_addr;
            end else if (jump) begin
                pc_n = jump_target;
            end else if (branch_taken) begin
                pc_n = branch_target;
            end else begin
                pc_n = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cause_q <= CAUSE_NONE;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            epc_q   <= epc_n;
            cause_q <= cause_n;
            trap_q  <= trap_n;
        end
    end

    assign pc     = pc_q;
    assign epc    = epc_q;
    assign cause  = cause_q;
    assign halted = (state_q == ST_HALT);
    assign trap   = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (WIDTH=64): directed stimulus pushes expected state
// into a queue; a negedge monitor pops and compares every observable output.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, jr, exception, eret, halt, resume;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic [63:0] jr_addr;
    logic [63:0] pc, pc_plus4, epc;
    logic [1:0]  cause;
    logic        halted, trap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [63:0] epc;
        logic [1:0]  cause;
        logic        halted;
        logic        trap;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(
        .WIDTH(64),
        .RESET_VECTOR(64'h0),
        .EXC_VECTOR(64'h80)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index),
        .jr(jr), .jr_addr(jr_addr),
        .exception(exception), .eret(eret),
        .halt(halt), .resume(resume),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .cause(cause),
        .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input string f, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "pc", pc, e.pc);
            cmp(e.name, "pc_plus4", pc_plus4, e.pc + 64'd4);
            cmp(e.name, "epc", epc, e.epc);
            cmp(e.name, "cause", 64'(cause), 64'(e.cause));
            cmp(e.name, "halted", 64'(halted), 64'(e.halted));
            cmp(e.name, "trap", 64'(trap), 64'(e.trap));
        end
    end

    task automatic idle();
        reset = 0; stall = 0; branch_taken = 0; branch_offset = '0;
        jump = 0; jump_index = '0; jr = 0; jr_addr = '0;
        exception = 0; eret = 0; halt = 0; resume = 0;
    endtask

    // inputs are already set by the caller; one clock edge is applied
    task automatic step(input string n, input logic [63:0] p, input logic [63:0] e,
                        input logic [1:0] c, input logic h, input logic t);
        exp_t x;
        x.name = n; x.pc = p; x.epc = e; x.cause = c; x.halted = h; x.trap = t;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        #1;
        idle();
    endtask

    task automatic go_jr(input string n, input logic [63:0] a, input logic [63:0] e, input logic [1:0] c);
        jr = 1; jr_addr = a;
        step(n, a, e, c, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #1;
        reset = 1;                step("reset", 64'h0, 64'h0, 2'd0, 0, 0);
        step("seq1", 64'h4, 64'h0, 2'd0, 0, 0);
        step("seq2", 64'h8, 64'h0, 2'd0, 0, 0);
        step("seq3", 64'hC, 64'h0, 2'd0, 0, 0);

        go_jr("jr100a", 64'h100, 64'h0, 2'd0);
        branch_taken = 1; branch_offset = 16'hFFFE;
        step("br_neg", 64'hFC, 64'h0, 2'd0, 0, 0);
        go_jr("jr100b", 64'h100, 64'h0, 2'd0);
        branch_taken = 1; branch_offset = 16'h0010;
        step("br_pos", 64'h144, 64'h0, 2'd0, 0, 0);

        go_jr("jr400010", 64'h0040_0010, 64'h0, 2'd0);
        jump = 1; jump_index = 26'h40; stall = 1;
        step("jump_stall", 64'h0040_0010, 64'h0, 2'd0, 0, 0);
        jump = 1; jump_index = 26'h40;
        step("jump", 64'h100, 64'h0, 2'd0, 0, 0);

        go_jr("jr200", 64'h200, 64'h0, 2'd0);
        jr = 1; jr_addr = 64'h302;
        step("jr_mis", 64'h80, 64'h200, 2'd2, 0, 1);
        eret = 1;
        step("eret1", 64'h200, 64'h200, 2'd0, 0, 0);

        go_jr("jr1c", 64'h1C, 64'h200, 2'd0);
        step("to20", 64'h20, 64'h200, 2'd0, 0, 0);
        halt = 1;                 step("halt", 64'h20, 64'h200, 2'd0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            branch_taken = 1; branch_offset = 16'h0010;
            step("halt_hold", 64'h20, 64'h200, 2'd0, 1, 0);
        end
        resume = 1;               step("resume", 64'h20, 64'h200, 2'd0, 0, 0);
        step("after_resume", 64'h24, 64'h200, 2'd0, 0, 0);
        halt = 1;                 step("halt2", 64'h24, 64'h200, 2'd0, 1, 0);
        halt = 1; resume = 1;     step("halt_resume", 64'h24, 64'h200, 2'd0, 0, 0);
        halt = 1;                 step("halt3", 64'h24, 64'h200, 2'd0, 1, 0);
        exception = 1;            step("exc_halt", 64'h80, 64'h24, 2'd1, 0, 1);
        step("trap_drop", 64'h84, 64'h24, 2'd1, 0, 0);
        eret = 1;                 step("eret2", 64'h24, 64'h24, 2'd0, 0, 0);
        stall = 1; exception = 1; step("stall_exc", 64'h80, 64'h24, 2'd1, 0, 1);
        stall = 1;                step("stall_hold", 64'h80, 64'h24, 2'd1, 0, 0);
        stall = 1; eret = 1;      step("stall_eret", 64'h24, 64'h24, 2'd0, 0, 0);

        go_jr("jr_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'h24, 2'd0);
        step("wrap", 64'h0, 64'h24, 2'd0, 0, 0);
        exception = 1;            step("exc_at0", 64'h80, 64'h0, 2'd1, 0, 1);
        reset = 1; exception = 1; step("reset_exc", 64'h0, 64'h0, 2'd0, 0, 0);
        step("idle4", 64'h4, 64'h0, 2'd0, 0, 0);
        halt = 1;                 step("halt4", 64'h4, 64'h0, 2'd0, 1, 0);
        reset = 1; resume = 0;    step("reset_halt", 64'h0, 64'h0, 2'd0, 0, 0);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 32, PC width in bits; legal range 32..64.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC value loaded on an exception.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- stall, input, 1, hold PC this cycle.
- branch_taken, input, 1, take the conditional branch.
- branch_offset, input, 16, signed word offset.
- jump, input, 1, J/JAL redirect.
- jump_index, input, 26, instruction index field.
- jr, input, 1, register-indirect redirect.
- jr_addr, input, WIDTH, register target.
- exception, input, 1, external trap request.
- eret, input, 1, return from exception.
- halt, input, 1, enter HALT.
- resume, input, 1, leave HALT.
- pc, output, WIDTH, current PC.
- pc_plus4, output, WIDTH, pc+4 (combinational).
- epc, output, WIDTH, exception return address.
- cause, output, 2, 0=none, 1=external, 2=misaligned jr.
- halted, output, 1, high in HALT state.
- trap, output, 1, one-cycle pulse on the cycle after any exception entry.

Function
REQ-003 Arithmetic SHALL be modulo 2^WIDTH:
- pc_plus4 = pc + 4.
- branch target = pc_plus4 + (sign-extended branch_offset << 2).
- jump target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00}.
REQ-004 In RUN state, the next PC SHALL be selected by fixed priority: exception > misaligned jr > eret > stall > jr > jump > branch_taken > pc_plus4.
REQ-005 A jr with jr_addr[1:0] != 0, when not masked by exception, SHALL act as an exception with cause=2; an aligned jr SHALL load jr_addr.
REQ-006 Exception entry (external, or misaligned jr) SHALL, on the same edge:
- load pc = EXC_VECTOR;
- capture epc = the current pc;
- set cause = 1 (external) or 2 (misaligned jr).
The trap pulse SHALL be asserted for the following cycle only.
REQ-007 eret SHALL load pc = epc and clear cause to 0; epc SHALL be unchanged.
REQ-008 stall SHALL hold pc and SHALL suppress jr, jump and branch; it SHALL NOT suppress exception or eret.
REQ-009 The state machine SHALL have states RUN and HALT:
- RUN -> HALT when halt=1 and no exception; pc holds on that edge.
- HALT -> RUN when resume=1; pc is unchanged.
- In HALT, pc, epc and cause hold; all inputs except reset, exception and resume are ignored.
- An exception in HALT performs REQ-006 and returns to RUN.
- Simultaneous halt and resume in HALT: resume wins.
REQ-010 halted SHALL equal (state == HALT), registered.
REQ-011 pc SHALL wrap from 2^WIDTH-4 to 0 on sequential increment, with no flag raised.

Reset
REQ-012 When reset=1 at a rising edge, the block SHALL set:
- pc = RESET_VECTOR, epc = 0, cause = 0, trap = 0;
- state = RUN, halted = 0.
REQ-013 reset SHALL override every other input, including mid-HALT and in the same cycle as an exception.
REQ-014 pc_plus4 SHALL reflect the reset pc combinationally in the cycle after reset.

Verification
REQ-015 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset, then 3 idle cycles -> pc = 0x0, 0x4, 0x8, 0xC.
- pc = 0x100, branch_taken=1 with branch_offset=0xFFFE -> pc = 0x0FC; branch_offset=0x0010 from 0x100 -> pc = 0x144.
- pc = 0x0040_0010, jump=1, jump_index=0x0000040 -> pc = 0x0000_0100; same cycle with stall=1 -> pc holds 0x0040_0010.
- pc = 0x200, jr=1, jr_addr=0x302 -> pc = 0x80, epc = 0x200, cause = 2, trap high for exactly one cycle; next eret -> pc = 0x200, cause = 0.
- halt at pc = 0x20, 4 cycles idle with branch_taken=1 -> pc stays 0x20, halted = 1; resume -> next cycle pc = 0x24.
- With WIDTH=64: pc = 0xFFFF_FFFF_FFFF_FFFC, idle -> pc = 0; reset asserted together with exception -> pc = RESET_VECTOR, cause = 0.
